// File: rtl/fnd_pkg.sv
// fnd_pkg -- definitions shared by the FND display scheduler.
//   disp_state_e : display selection state. Bit 1 is the source (1 = stopwatch)
//                  and bit 0 is the field pair (1 = msec/sec), so both outputs
//                  decode directly from the state bits.
//   CMD_*        : recognised ASCII UART command bytes.
//   *_LSB/*_W    : bit offsets and widths of the packed 24-bit time word.
//   min_hour_nz  : helper that is true when the minute or hour field is non-zero.
package fnd_pkg;

  typedef enum logic [1:0] {
    WT_HM = 2'b00,
    WT_MS = 2'b01,
    SW_HM = 2'b10,
    SW_MS = 2'b11
  } disp_state_e;

  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_M = 8'h4D;
  localparam logic [7:0] CMD_H = 8'h48;

  localparam int HOUR_LSB = 19;
  localparam int HOUR_W   = 5;
  localparam int MIN_LSB  = 13;
  localparam int MIN_W    = 6;
  localparam int SEC_LSB  = 7;
  localparam int SEC_W    = 6;
  localparam int MSEC_LSB = 0;
  localparam int MSEC_W   = 7;

  function automatic logic min_hour_nz(input logic [23:0] t);
    return (t[MIN_LSB +: MIN_W] != 6'd0) || (t[HOUR_LSB +: HOUR_W] != 5'd0);
  endfunction

endpackage

// File: rtl/fnd_disp_sched_tick_gen_1ms.sv
// tick_gen_1ms -- free-running divider producing a one-cycle pulse every 1 ms.
// Ports:
//   clk    : system clock (posedge)
//   reset  : synchronous active-low reset
//   o_tick : registered one-cycle pulse, once per CLK_HZ/1000 cycles
module tick_gen_1ms
  import fnd_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider counter: wraps at DIV-1 and emits the tick on the wrap cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= {CW{1'b0}};
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= {CW{1'b0}};
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/fnd_disp_sched.sv
// fnd_disp_sched -- selects which time word and field pair the FND shows.
// Optional feature macro: FND_AUTO_FIELD_EN (auto switch SW_MS -> SW_HM when
// the stopwatch minute/hour becomes non-zero).
// Ports:
//   clk, reset          : system clock, synchronous active-low reset
//   i_sw_time/i_wt_time : stopwatch / watch time {hour,min,sec,msec}
//   i_btn_src/i_btn_field : one-cycle button pulses (debounced upstream)
//   i_uart_valid/i_uart_cmd : UART command strobe and byte ('S','W','M','H')
//   o_time              : registered selected time word
//   o_mode              : 1 = msec/sec, 0 = min/hour
//   o_src               : 1 = stopwatch, 0 = watch
//   o_uart_ack          : one-cycle pulse for each recognised UART command
module fnd_disp_sched
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int LOCK_MS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] i_sw_time,
  input  logic [23:0] i_wt_time,
  input  logic        i_btn_src,
  input  logic        i_btn_field,
  input  logic        i_uart_valid,
  input  logic [7:0]  i_uart_cmd,
  output logic [23:0] o_time,
  output logic        o_mode,
  output logic        o_src,
  output logic        o_uart_ack
);

  localparam int LW = $clog2(LOCK_MS + 1);

  disp_state_e r_state;
  disp_state_e w_state_nxt;
  logic [LW-1:0] r_lock;
  logic [23:0]   r_time;
  logic          r_ack;
  logic          w_tick;
  logic          w_uart_hit;
  logic          w_btn_acc;
  logic          w_src_nxt;
  logic          w_mode_nxt;

  tick_gen_1ms #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // UART decode: only the four command bytes count as a hit.
  always_comb begin
    w_uart_hit = 1'b0;
    case (i_uart_cmd)
      CMD_S, CMD_W, CMD_M, CMD_H: w_uart_hit = i_uart_valid;
      default:                    w_uart_hit = 1'b0;
    endcase
  end

  // A button is accepted only outside lockout and only when no UART command
  // shares the cycle (UART wins and the button pulse is dropped).
  assign w_btn_acc = !w_uart_hit && (i_btn_src || i_btn_field) && (r_lock == {LW{1'b0}});

`ifdef FND_AUTO_FIELD_EN
  logic r_auto_nz;
  logic w_auto_edge;

  assign w_auto_edge = min_hour_nz(i_sw_time) && !r_auto_nz && (r_state == SW_MS);

  // Edge register for the stopwatch minute/hour non-zero condition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_auto_nz <= 1'b0;
    end else begin
      r_auto_nz <= min_hour_nz(i_sw_time);
    end
  end
`endif

  // Next-state: UART sets an axis absolutely, buttons toggle, auto edge last.
  always_comb begin
    w_src_nxt  = r_state[1];
    w_mode_nxt = r_state[0];
    if (w_uart_hit) begin
      case (i_uart_cmd)
        CMD_S:   w_src_nxt  = 1'b1;
        CMD_W:   w_src_nxt  = 1'b0;
        CMD_M:   w_mode_nxt = 1'b1;
        CMD_H:   w_mode_nxt = 1'b0;
        default: w_src_nxt  = r_state[1];
      endcase
    end else if (w_btn_acc) begin
      if (i_btn_src) begin
        w_src_nxt = ~r_state[1];
      end else begin
        w_src_nxt = r_state[1];
      end
      if (i_btn_field) begin
        w_mode_nxt = ~r_state[0];
      end else begin
        w_mode_nxt = r_state[0];
      end
`ifdef FND_AUTO_FIELD_EN
    end else if (w_auto_edge) begin
      w_mode_nxt = 1'b0;
`endif
    end else begin
      w_mode_nxt = r_state[0];
    end
    w_state_nxt = disp_state_e'({w_src_nxt, w_mode_nxt});
  end

  // State, ack, time word and lockout registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= WT_HM;
      r_ack   <= 1'b0;
      r_time  <= 24'h000000;
      r_lock  <= {LW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_uart_hit;
      r_time  <= r_state[1] ? i_sw_time : i_wt_time;
      if (w_btn_acc) begin
        r_lock <= LW'(LOCK_MS);
      end else if (w_tick && (r_lock != {LW{1'b0}})) begin
        r_lock <= r_lock - LW'(1);
      end else begin
        r_lock <= r_lock;
      end
    end
  end

  assign o_src      = r_state[1];
  assign o_mode     = r_state[0];
  assign o_time     = r_time;
  assign o_uart_ack = r_ack;

endmodule

// File: tb/tb_fnd_disp_sched.sv
// Bench for fnd_disp_sched with a 10 kHz clock (10 cycles per ms) so the
// 50 ms lockout spans 500 cycles. A cycle-level reference model predicts the
// outputs and is compared every negedge; literal checks pin key scenarios.
// Button presses are never placed within the last ms of a lockout window,
// where the phase of the free-running 1 ms tick decides acceptance.
module tb_fnd_disp_sched;

  localparam int CLK_HZ   = 10_000;
  localparam int LOCK_MS  = 50;
  localparam int DIV      = CLK_HZ / 1000;
  localparam int LOCK_CYC = LOCK_MS * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] i_sw_time, i_wt_time;
  logic        i_btn_src, i_btn_field, i_uart_valid;
  logic [7:0]  i_uart_cmd;
  logic [23:0] o_time;
  logic        o_mode, o_src, o_uart_ack;

  int n_err = 0;
  int n_chk = 0;

  fnd_disp_sched #(.CLK_HZ(CLK_HZ), .LOCK_MS(LOCK_MS)) dut (
    .clk(clk), .reset(reset), .i_sw_time(i_sw_time), .i_wt_time(i_wt_time),
    .i_btn_src(i_btn_src), .i_btn_field(i_btn_field),
    .i_uart_valid(i_uart_valid), .i_uart_cmd(i_uart_cmd),
    .o_time(o_time), .o_mode(o_mode), .o_src(o_src), .o_uart_ack(o_uart_ack)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  logic        m_src, m_mode, m_ack, m_prev_nz;
  logic [23:0] m_time;
  int          m_cyc = 0;
  int          m_last_acc;

  function automatic bit is_cmd(input logic v, input logic [7:0] c);
    return v && (c == 8'h53 || c == 8'h57 || c == 8'h4D || c == 8'h48);
  endfunction

  function automatic bit nz(input logic [23:0] t);
    return (t[18:13] != 6'd0) || (t[23:19] != 5'd0);
  endfunction

  always @(posedge clk) begin
    m_cyc <= m_cyc + 1;
    if (!reset) begin
      m_valid    <= 1'b1;
      m_src      <= 1'b0;
      m_mode     <= 1'b0;
      m_ack      <= 1'b0;
      m_time     <= 24'h000000;
      m_prev_nz  <= 1'b0;
      m_last_acc <= -1000000;
    end else begin
      m_ack     <= is_cmd(i_uart_valid, i_uart_cmd);
      m_time    <= m_src ? i_sw_time : i_wt_time;
      m_prev_nz <= nz(i_sw_time);
      if (is_cmd(i_uart_valid, i_uart_cmd)) begin
        case (i_uart_cmd)
          8'h53:   m_src  <= 1'b1;
          8'h57:   m_src  <= 1'b0;
          8'h4D:   m_mode <= 1'b1;
          default: m_mode <= 1'b0;
        endcase
      end else if ((i_btn_src || i_btn_field) && (m_cyc - m_last_acc > LOCK_CYC)) begin
        if (i_btn_src)   m_src  <= ~m_src;
        if (i_btn_field) m_mode <= ~m_mode;
        m_last_acc <= m_cyc;
      end
`ifdef FND_AUTO_FIELD_EN
      else if (m_src && m_mode && nz(i_sw_time) && !m_prev_nz) begin
        m_mode <= 1'b0;
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_src",  {31'd0, o_src},      {31'd0, m_src});
      chk("cyc_mode", {31'd0, o_mode},     {31'd0, m_mode});
      chk("cyc_ack",  {31'd0, o_uart_ack}, {31'd0, m_ack});
      chk("cyc_time", {8'd0, o_time},      {8'd0, m_time});
    end
  end

  // ---------------- stimulus ----------------
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic bs, input logic bf, input logic uv, input logic [7:0] cmd);
    i_btn_src    = bs;
    i_btn_field  = bf;
    i_uart_valid = uv;
    i_uart_cmd   = cmd;
    adv(1);
    i_btn_src    = 1'b0;
    i_btn_field  = 1'b0;
    i_uart_valid = 1'b0;
    i_uart_cmd   = 8'h00;
  endtask

  initial begin
    reset        = 1'b0;
    i_wt_time    = 24'h123456;
    i_sw_time    = 24'h000A0B;
    i_btn_src    = 1'b0;
    i_btn_field  = 1'b0;
    i_uart_valid = 1'b0;
    i_uart_cmd   = 8'h00;
    adv(3);
    chk("rst_time", {8'd0, o_time}, 32'h0);
    chk("rst_sm", {30'd0, o_src, o_mode}, 32'd0);
    chk("rst_ack", {31'd0, o_uart_ack}, 32'd0);

    // Reset release: watch time appears one cycle later.
    reset = 1'b1;
    adv(1);
    chk("rel_time", {8'd0, o_time}, 32'h00123456);
    chk("rel_sm", {30'd0, o_src, o_mode}, 32'd0);

    // Field toggle, a press 10 ms later ignored, a press at 60 ms accepted.
    press(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fld1", {30'd0, o_src, o_mode}, 32'd1);
    adv(99);
    press(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fld_locked", {30'd0, o_src, o_mode}, 32'd1);
    adv(499);
    press(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fld_60ms", {30'd0, o_src, o_mode}, 32'd0);

    // UART 'S' with a field press in the same cycle: UART wins, no lockout.
    adv(600);
    press(1'b0, 1'b1, 1'b1, 8'h53);
    chk("uart_win", {30'd0, o_src, o_mode}, 32'd2);
    chk("ack_hi", {31'd0, o_uart_ack}, 32'd1);
    press(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ack_lo", {31'd0, o_uart_ack}, 32'd0);
    chk("btn_after_uart", {30'd0, o_src, o_mode}, 32'd3);
    adv(1);
    chk("sw_time", {8'd0, o_time}, 32'h00000A0B);

    // Unrecognised command, then W / H, then W again while already WT_HM.
    press(1'b0, 1'b0, 1'b1, 8'h41);
    chk("bad_cmd_ack", {31'd0, o_uart_ack}, 32'd0);
    chk("bad_cmd_st", {30'd0, o_src, o_mode}, 32'd3);
    press(1'b0, 1'b0, 1'b1, 8'h57);
    press(1'b0, 1'b0, 1'b1, 8'h48);
    chk("wh", {30'd0, o_src, o_mode}, 32'd0);
    press(1'b0, 1'b0, 1'b1, 8'h57);
    chk("w_same_ack", {31'd0, o_uart_ack}, 32'd1);
    chk("w_same_st", {30'd0, o_src, o_mode}, 32'd0);
    // Still inside lockout from the last accepted press.
    press(1'b1, 1'b0, 1'b0, 8'h00);
    chk("src_locked", {30'd0, o_src, o_mode}, 32'd0);

    // Diagonal move with both buttons.
    adv(600);
    press(1'b1, 1'b1, 1'b0, 8'h00);
    chk("diag", {30'd0, o_src, o_mode}, 32'd3);

    // Reset 20 ms into lockout; first press after release is accepted.
    adv(199);
    reset = 1'b0;
    adv(3);
    chk("mid_rst_sm", {30'd0, o_src, o_mode}, 32'd0);
    chk("mid_rst_time", {8'd0, o_time}, 32'h0);
    chk("mid_rst_ack", {31'd0, o_uart_ack}, 32'd0);
    reset = 1'b1;
    press(1'b1, 1'b0, 1'b0, 8'h00);
    chk("post_rst_btn", {30'd0, o_src, o_mode}, 32'd2);

    // Stopwatch minute 0 -> 1 while in SW_MS.
    press(1'b0, 1'b0, 1'b1, 8'h4D);
    chk("sw_ms", {30'd0, o_src, o_mode}, 32'd3);
    i_sw_time = 24'h002005;
    adv(1);
`ifdef FND_AUTO_FIELD_EN
    chk("auto_hm", {30'd0, o_src, o_mode}, 32'd2);
`else
    chk("no_auto", {30'd0, o_src, o_mode}, 32'd3);
`endif
    press(1'b0, 1'b0, 1'b1, 8'h4D);
    adv(5);
    chk("m_holds", {30'd0, o_src, o_mode}, 32'd3);
    chk("sw_time2", {8'd0, o_time}, 32'h00002005);

    adv(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
